// File: rtl/hsk_io_port.sv
// Peripheral end of a four-phase processor handshake. Each accepted request swaps one byte:
// the request byte goes into an RX FIFO and the TX FIFO head is returned on p_bus_in.
module hsk_io_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     g_clk,
  input  logic                     g_clr,
  input  logic [WIDTH-1:0]         p_bus_out,
  input  logic                     p_hsk_out,
  output logic [WIDTH-1:0]         p_bus_in,
  output logic                     p_hsk_in,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_wr,
  output logic                     tx_full,
  output logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_rd,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     underrun,
  output logic [1:0]               dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Handshake: a request (p_hsk_out=1) seen in IDLE with RX space is accepted on that edge and
  // answered with p_hsk_in=1; p_hsk_in stays high until p_hsk_out is seen low, then stays low
  // for at least the one RELEASE cycle before another request can be accepted.
  state_e             state_q;
  logic               hsk_in_q;
  logic [WIDTH-1:0]   bus_in_q;
  logic               underrun_q;

  logic [WIDTH-1:0]   tx_mem_q [DEPTH];
  logic [AW-1:0]      tx_wptr_q, tx_rptr_q;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic               tx_empty, tx_full_w, tx_push, tx_pop;

  logic [WIDTH-1:0]   rx_mem_q [DEPTH];
  logic [AW-1:0]      rx_wptr_q, rx_rptr_q;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic               rx_empty_w, rx_full_w, rx_push, rx_pop;

  logic               accept;

  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_full_w  = (tx_cnt_q == FULL_CNT);
  assign rx_empty_w = (rx_cnt_q == '0);
  assign rx_full_w  = (rx_cnt_q == FULL_CNT);

  // RX occupancy is taken before any same-cycle pop, so a full FIFO stalls one extra cycle.
  assign accept  = (state_q == ST_IDLE) && p_hsk_out && !rx_full_w;

  assign tx_push = tx_wr && !tx_full_w;
  assign tx_pop  = accept && !tx_empty;
  assign rx_push = accept;
  assign rx_pop  = rx_rd && !rx_empty_w;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge g_clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= tx_data;
    if (rx_push) rx_mem_q[rx_wptr_q] <= p_bus_out;
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state_q    <= ST_IDLE;
      hsk_in_q   <= 1'b0;
      bus_in_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q  <= ST_ACK;
            hsk_in_q <= 1'b1;
            if (tx_empty) begin
              bus_in_q   <= '0;
              underrun_q <= 1'b1;
            end else begin
              bus_in_q <= tx_mem_q[tx_rptr_q];
            end
          end
        end
        ST_ACK: begin
          if (!p_hsk_out) begin
            state_q  <= ST_RELEASE;
            hsk_in_q <= 1'b0;
          end
        end
        ST_RELEASE: begin
          state_q  <= ST_IDLE;
          hsk_in_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          hsk_in_q <= 1'b0;
        end
      endcase
    end
  end

  assign p_hsk_in    = hsk_in_q;
  assign p_bus_in    = bus_in_q;
  assign underrun    = underrun_q;
  assign tx_full     = tx_full_w;
  assign rx_empty    = rx_empty_w;
  assign rx_count    = rx_cnt_q;
  assign rx_data     = rx_mem_q[rx_rptr_q];
  assign dbg_state_o = state_q;

endmodule

// File: doc/hsk_io_port.md
HSK_IO_PORT -- requirements
Module: hsk_io_port

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data byte width.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the entries per FIFO; the value SHALL be a power of two.
REQ-003 g_clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 g_clr  input  1  asynchronous, active-high reset.
REQ-005 p_bus_out  input  WIDTH  byte driven by the processor.
REQ-006 p_hsk_out  input  1  processor request, four-phase.
REQ-007 p_bus_in  output  WIDTH  byte returned to the processor.
REQ-008 p_hsk_in  output  1  acknowledge to the processor.
REQ-009 tx_data  input  WIDTH  host byte queued for the processor.
REQ-010 tx_wr  input  1  push tx_data into the TX FIFO.
REQ-011 tx_full  output  1  TX FIFO holds DEPTH entries.
REQ-012 rx_data  output  WIDTH  head of the RX FIFO; combinational.
REQ-013 rx_rd  input  1  pop the RX FIFO.
REQ-014 rx_empty  output  1  RX FIFO holds 0 entries.
REQ-015 rx_count  output  log2(DEPTH)+1  current RX occupancy.
REQ-016 underrun  output  1  sticky flag: a transfer was served while the TX FIFO was empty.

Function
REQ-017 The module SHALL act as the peripheral end of the processor's four-phase handshake. Each transfer SHALL swap one byte in each direction.
REQ-018 The FSM SHALL have three states: IDLE, ACK and RELEASE.
REQ-019 IDLE -> ACK SHALL occur on an edge where p_hsk_out=1 and rx_count<DEPTH, with rx_count sampled before any same-cycle rx_rd. On that edge the module SHALL:
- push p_bus_out into the RX FIFO;
- load p_bus_in with the TX head and pop the TX FIFO;
- set p_hsk_in=1.
REQ-020 If p_hsk_out=1 while the RX FIFO is full, the FSM SHALL stay in IDLE with p_hsk_in=0 until space exists; the stall length is unbounded.
REQ-021 If the TX FIFO is empty at acceptance, p_bus_in SHALL load 0 and underrun SHALL set; it SHALL stay set until g_clr.
REQ-022 ACK -> RELEASE SHALL occur on the first edge with p_hsk_out=0; on that edge p_hsk_in SHALL clear. p_hsk_in SHALL stay 1 for as long as p_hsk_out remains 1.
REQ-023 RELEASE -> IDLE SHALL occur unconditionally after one cycle, so that p_hsk_in is low for at least one cycle between transfers.
REQ-024 p_bus_in SHALL hold its value from acceptance until the next acceptance.
REQ-025 p_hsk_in SHALL be a registered output.
REQ-026 Minimum transfer timing: acceptance at edge k, ack visible after edge k, release at edge k+2 if p_hsk_out drops after k+1, next acceptance no earlier than k+3.
REQ-027 A tx_wr while tx_full SHALL be ignored, with contents and pointers unchanged.
REQ-028 An rx_rd while rx_empty SHALL be ignored.
REQ-029 A tx_wr in the same cycle as a TX pop by acceptance SHALL do both: the pop takes the old head, and the count is unchanged. If the TX FIFO was empty, the written byte SHALL be stored, p_bus_in SHALL be 0 and underrun SHALL set.
REQ-030 An rx_rd in the same cycle as an RX push SHALL do both, with the count unchanged; this applies only when acceptance was allowed under REQ-019.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH. Counts SHALL range from 0 to DEPTH, with no aliasing between full and empty.

Reset
REQ-032 While g_clr=1, the module SHALL hold: state IDLE, p_hsk_in=0, p_bus_in=0, both FIFOs empty, rx_count=0, rx_empty=1, tx_full=0, underrun=0.
REQ-033 g_clr asserted in ACK or RELEASE SHALL abort the transfer: p_hsk_in drops immediately and the captured RX byte is discarded.
REQ-034 After g_clr deasserts with p_hsk_out still 1, the request SHALL be accepted as new on the first edge.

Verification
REQ-035 Basic swap: push tx 0xA5, then processor drives 0x3C with hsk_out=1. Required: p_hsk_in=1 one edge later, p_bus_in=0xA5; after hsk_out drops, hsk_in=0 next edge; rx_data=0x3C, rx_count=1.
REQ-036 Empty TX: a transfer of 0x11 with no tx data. Required: p_bus_in=0x00, underrun=1 and still set after 3 further transfers.
REQ-037 RX full stall: 4 transfers 0x01..0x04 with no rx_rd, then a 5th request of 0x05. Required: hsk_in stays 0 for 10 cycles. After one rx_rd returns 0x01, the 5th transfer is acked and the FIFO later drains 0x02, 0x03, 0x04, 0x05.
REQ-038 Simultaneous events: tx_wr 0x77 in the acceptance cycle with TX empty. Required: p_bus_in=0x00, underrun=1, and the next transfer returns 0x77. A separate case: rx_rd in the push cycle at count 2 leaves count 2.
REQ-039 Overflow and wrap: 5 tx_wr pushes 0x10..0x14. Required: 0x14 is dropped and tx_full=1; 8 transfers with interleaved refills return bytes in order across the pointer wrap.
REQ-040 Reset mid-transfer: g_clr pulsed in ACK. Required: hsk_in=0 asynchronously and rx_count=0; with hsk_out held 1, a new ack occurs on the first edge after release.
